rom_share_ctrl: RTL
===================

# rom_share_ctrl

Read controller that lets both PicoBlaze cores share one single-port synchronous constant ROM, replacing a dual-read array with one physical port. It arbitrates between requester 0 and requester 1, adds each requester's base offset, range-checks the result, sequences the ROM access, and returns data with an acknowledge pulse. It sits between the two cores' input-port decode logic and the ROM.

## Interface
- DATA_W, 8: ROM and data port width.
- ADDR_W, 8: requester and ROM address width.
- DEPTH, 200: number of valid ROM words.
- BASE0, 0: offset added to requester 0 addresses.
- BASE1, 100: offset added to requester 1 addresses.
- ROM_LAT, 1: ROM read latency in cycles, from rom_en to valid rom_data. Legal range is 1..4.
- clk  in  1  single system clock; everything is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  access request, level-sensitive.
- addr0 / addr1  in  ADDR_W  requester address; must be held stable while req is high.
- ack0 / ack1  out  1  one-cycle completion pulse.
- data0 / data1  out  DATA_W  read result; held until that requester's next ack.
- err0 / err1  out  1  out-of-range flag; valid with ack and held like data.
- rom_en  out  1  ROM read strobe.
- rom_addr  out  ADDR_W  ROM address.
- rom_data  in  DATA_W  ROM output.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, DONE.
- IDLE: sample req0 and req1.
  - If one request is pending, grant it.
  - If both are pending, grant the requester other than last_gnt (round-robin).
  - Compute sum = addrN + BASEn at ADDR_W+1 bits so there is no wrap.
  - If sum < DEPTH, latch rom_addr = sum[ADDR_W-1:0] and go to ISSUE.
  - Otherwise go directly to DONE with err set and data forced to 0x00.
- ISSUE: rom_en = 1 for exactly one cycle, then go to WAIT with the counter loaded to ROM_LAT-1.
- WAIT: count down. When the count reaches 0, capture rom_data into the granted dataN at that edge and go to DONE.
- DONE: ackN = 1 and errN is valid. Update last_gnt to N, then return to IDLE.
- The ungranted requester's outputs never change during an access.
- A requester that keeps req high after its ack is treated as making a new request at the next IDLE sample.
- Address or req changes while not in IDLE are ignored; the latched values are used.
- Reset values:
  - State IDLE.
  - last_gnt = 1, so requester 0 wins the first tie.
  - All ack and err outputs 0; data0 and data1 = 0.
  - rom_en = 0, rom_addr = 0, busy = 0.
- Reset mid-access aborts the access. No ack is issued, and the requester must re-request.

## Timing
- In-range access: req is sampled at edge E0, ISSUE runs in cycle 1, and ack appears in cycle 2+ROM_LAT. With ROM_LAT=1, ack is in cycle 3.
- Out-of-range access: ack and err appear in cycle 1.
- Throughput: one access every 3+ROM_LAT cycles. Back-to-back ties alternate between requesters.
- rom_addr is stable from ISSUE through the last WAIT cycle.
- dataN and errN are registered and change only on the edge that raises ackN.
- busy is a registered decode of the state.

## Configuration
- ROM_SHARE_FIXED_PRIO_EN defined: on a tie, requester 0 always wins. last_gnt is still updated but ignored.
- Not defined: round-robin as described above.
- No other behaviour differs between the two builds.

## Structure
- Shared package/header rom_share_pkg contains:
  - State encodings: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3.
  - Default DEPTH, BASE0 and BASE1.
- Sub-module rom_share_pick: a combinational 2-way grant selector.
  - Inputs: req0, req1, last_gnt.
  - Outputs: gnt_valid, gnt_id.
  - Contains the FIXED_PRIO macro switch.

## Test plan
- Single in-range read: req0=1, addr0=3, ROM_LAT=1 -> rom_en in cycle 1, rom_addr=3; ack0 in cycle 3, data0 = ROM[3], err0=0.
- Requester 1 offset: req1=1, addr1=80 -> rom_addr=180, data1 = ROM[180].
- Range boundary, requester 1 (DEPTH=200, BASE1=100):
  - addr1=99 -> rom_addr=199 and normal read.
  - addr1=100 -> no rom_en, ack1 in cycle 1, err1=1, data1=0x00.
  - addr1=255 -> same as addr1=100, confirming the sum does not wrap.
- Tie with both requests held high after reset -> grants in order 0,1,0,1. With ROM_SHARE_FIXED_PRIO_EN defined -> grants 0,0,0.
- Reset mid-access: deassert reset_n while in WAIT -> no ack, all outputs at reset values, busy=0. After release, the re-asserted req completes normally.
- ROM_LAT=4: a single read acks in cycle 6, and rom_addr stays stable through WAIT.

Source files
------------

// File: rtl/rom_share_pkg.sv
// rom_share_pkg: shared definitions for the shared constant-ROM read controller.
//   state_t      - controller FSM encoding (IDLE/ISSUE/WAIT/DONE)
//   DEF_*        - default geometry: ROM depth, per-requester base offsets,
//                  data/address widths and ROM read latency
//   CNT_W        - width of the ROM latency down-counter (ROM_LAT is 1..4)
package rom_share_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DEPTH   = 200;
  localparam int DEF_BASE0   = 0;
  localparam int DEF_BASE1   = 100;
  localparam int DEF_ROM_LAT = 1;

  localparam int CNT_W = 2;

endpackage

// File: rtl/rom_share_pick.sv
// rom_share_pick: combinational 2-way grant selector.
//   req0, req1  in  pending requests
//   last_gnt    in  requester granted most recently (0/1)
//   gnt_valid   out at least one request pending
//   gnt_id      out granted requester
// Build option: ROM_SHARE_FIXED_PRIO_EN - when defined, requester 0 wins every
// tie and last_gnt is ignored; otherwise ties alternate (round-robin).
module rom_share_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic gnt_valid,
  output logic gnt_id
);

`ifdef ROM_SHARE_FIXED_PRIO_EN
  // last_gnt is still tracked by the controller but has no say here.
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;
`endif

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = 1'b0;
    if (req0 && req1) begin
`ifdef ROM_SHARE_FIXED_PRIO_EN
      gnt_id = 1'b0;
`else
      // Tie: hand the port to whoever did not have it last time.
      gnt_id = ~last_gnt;
`endif
    end else begin
      gnt_id = req1;
    end
  end

endmodule

// File: rtl/rom_share_ctrl.sv
// rom_share_ctrl: lets two PicoBlaze cores share one single-port synchronous
// constant ROM. Arbitrates, adds the per-requester base offset, range-checks,
// sequences the ROM read and returns data with a one-cycle acknowledge.
//   clk, reset_n        clock (rising edge) / async active-low reset
//   req0/req1           level request; addr0/addr1 held while req is high
//   ack0/ack1           one-cycle completion pulse
//   data0/data1         read result, held until that requester's next ack
//   err0/err1           out-of-range flag, valid with ack, held like data
//   rom_en/rom_addr     ROM read strobe / address
//   rom_data            ROM output, valid ROM_LAT cycles after rom_en
//   busy                registered "state != IDLE"
// Build option: ROM_SHARE_FIXED_PRIO_EN (see rom_share_pick).
module rom_share_ctrl
  import rom_share_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int BASE0   = DEF_BASE0,
  parameter int BASE1   = DEF_BASE1,
  parameter int ROM_LAT = DEF_ROM_LAT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] data0,
  output logic [DATA_W-1:0] data1,
  output logic              err0,
  output logic              err1,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
);

  localparam logic [ADDR_W:0]  BASE0_X = (ADDR_W+1)'(BASE0);
  localparam logic [ADDR_W:0]  BASE1_X = (ADDR_W+1)'(BASE1);
  localparam logic [31:0]      DEPTH_U = 32'(DEPTH);
  localparam logic [CNT_W-1:0] LAT_M1  = CNT_W'(ROM_LAT - 1);

  state_t              state_q;
  logic                gnt_q;
  logic                last_gnt_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                ack0_q, ack1_q;
  logic                err0_q, err1_q;
  logic [DATA_W-1:0]   data0_q, data1_q;
  logic                rom_en_q;
  logic [ADDR_W-1:0]   rom_addr_q;
  logic                busy_q;

  logic                gnt_valid;
  logic                gnt_id;
  logic [ADDR_W-1:0]   sel_addr;
  logic [ADDR_W:0]     sel_base;
  logic [ADDR_W:0]     sum_d;
  logic                in_range_d;

  rom_share_pick u_pick (
    .req0      (req0),
    .req1      (req1),
    .last_gnt  (last_gnt_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // One extra bit on the sum so a large address plus offset cannot wrap
  // back into the valid range.
  always_comb begin
    sel_addr   = gnt_id ? addr1 : addr0;
    sel_base   = gnt_id ? BASE1_X : BASE0_X;
    sum_d      = {1'b0, sel_addr} + sel_base;
    in_range_d = 32'(sum_d) < DEPTH_U;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;   // requester 0 wins the first tie
      cnt_q      <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
      data0_q    <= '0;
      data1_q    <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            gnt_q  <= gnt_id;
            busy_q <= 1'b1;
            if (in_range_d) begin
              rom_addr_q <= sum_d[ADDR_W-1:0];
              rom_en_q   <= 1'b1;
              state_q    <= ISSUE;
            end else begin
              // Out of range: skip the ROM entirely and complete now.
              state_q <= DONE;
              if (gnt_id) begin
                ack1_q  <= 1'b1;
                err1_q  <= 1'b1;
                data1_q <= '0;
              end else begin
                ack0_q  <= 1'b1;
                err0_q  <= 1'b1;
                data0_q <= '0;
              end
            end
          end
        end
        ISSUE: begin
          rom_en_q <= 1'b0;
          cnt_q    <= LAT_M1;
          state_q  <= WAIT;
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= DONE;
            if (gnt_q) begin
              ack1_q  <= 1'b1;
              err1_q  <= 1'b0;
              data1_q <= rom_data;
            end else begin
              ack0_q  <= 1'b1;
              err0_q  <= 1'b0;
              data0_q <= rom_data;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          last_gnt_q <= gnt_q;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          state_q  <= IDLE;
          rom_en_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign err0     = err0_q;
  assign err1     = err1_q;
  assign data0    = data0_q;
  assign data1    = data1_q;
  assign rom_en   = rom_en_q;
  assign rom_addr = rom_addr_q;
  assign busy     = busy_q;

endmodule
